tdc_coarse_cnt: RTL and testbench

- Consumer end of the TDC start/stop synchronizer interface.
- Counts `clk5` cycles while `cnt_en` is high and captures the count on each `coarse_tri` pulse into a small hit FIFO.
- Drives `overflow` back to the synchronizer when the measurement range is exhausted, which closes the window.
- Hits are read out through a valid/ready port; each measurement window is closed with a one-cycle `frame_done` pulse.

---
 rtl/tdc_coarse_cnt.sv | 177 +++++++++++++++++
 tb/tb_tdc_coarse_cnt.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_coarse_cnt.sv
// TDC coarse counter: counts clk5 cycles inside a measurement window and queues stop-pulse timestamps.
// Optional feature macro: COARSE_DROP_CNT_EN adds the hit_drop saturating drop counter port.

// Small hit queue with registered occupancy flag and reset-cleared storage.
// Latency: push visible on head one cycle later when empty.
// Backpressure: pop only when head_vld && pop_rdy; push refused when full unless a pop frees a slot.
module tdc_hit_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk5,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic         push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          pop_ok;

    always_comb begin
        pop_ok    = pop_rdy && head_vld;
        push_ok   = push_vld && ((count != FULL_CNT) || pop_ok);
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + CNT_ONE;
        else if (pop_ok && !push_ok)
            count_nxt = count - CNT_ONE;
    end

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk5 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            count    <= count_nxt;
            head_vld <= (count_nxt != '0);
        end
    end
endmodule

// Window FSM (IDLE/RUN/OVF/DONE) with live coarse counter and stop-pulse capture into the hit queue.
// Latency: count visible the cycle after the window opens; captured hit valid one cycle after the stop pulse.
// Backpressure: hit_valid/hit_ready; hits arriving while the queue is full and not draining are dropped.
module tdc_coarse_cnt #(
    parameter int CNT_W     = 12,
    parameter int MAX_CNT   = 4095,
    parameter int HIT_DEPTH = 4
) (
    input  logic                           clk5,
    input  logic                           rst,
    input  logic                           cnt_en,
    input  logic                           coarse_tri,
    output logic                           overflow,
    output logic [CNT_W-1:0]               coarse_cnt,
    output logic                           hit_valid,
    input  logic                           hit_ready,
    output logic [CNT_W-1:0]               hit_data,
    output logic [$clog2(HIT_DEPTH):0]     hit_cnt,
    output logic                           frame_done
`ifdef COARSE_DROP_CNT_EN
    ,
    output logic [7:0]                     hit_drop
`endif
);
    localparam int HC_W = $clog2(HIT_DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
    localparam logic [HC_W-1:0]  HC_MAX = HC_W'(HIT_DEPTH);
    localparam logic [HC_W-1:0]  HC_1   = HC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVF, S_DONE} state_t;

    state_t state;
    logic   push_vld;
    logic   push_ok;

    // Stop pulses only count while the window is running; the range-edge pulse is still in RUN.
    assign push_vld = (state == S_RUN) && coarse_tri;

    tdc_hit_fifo #(
        .W     (CNT_W),
        .DEPTH (HIT_DEPTH)
    ) u_fifo (
        .clk5     (clk5),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (coarse_cnt),
        .pop_rdy  (hit_ready),
        .head_vld (hit_valid),
        .head_dat (hit_data),
        .push_ok  (push_ok)
    );

    always_ff @(posedge clk5 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            overflow   <= 1'b0;
            coarse_cnt <= '0;
            hit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cnt_en) begin
                        state      <= S_RUN;
                        coarse_cnt <= '0;
                        hit_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (push_ok && (hit_cnt != HC_MAX))
                        hit_cnt <= hit_cnt + HC_1;
                    // Range exhaustion wins over a simultaneous window close.
                    if (coarse_cnt == MAX_V) begin
                        state    <= S_OVF;
                        overflow <= 1'b1;
                    end else if (!cnt_en) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        coarse_cnt <= '0;
                    end else begin
                        coarse_cnt <= coarse_cnt + CNT_1;
                    end
                end
                S_OVF: begin
                    if (!cnt_en) begin
                        state      <= S_DONE;
                        overflow   <= 1'b0;
                        frame_done <= 1'b1;
                        coarse_cnt <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COARSE_DROP_CNT_EN
    always_ff @(posedge clk5 or posedge rst) begin
        if (rst)
            hit_drop <= '0;
        else if ((state == S_IDLE) && cnt_en)
            hit_drop <= '0;
        else if (push_vld && !push_ok && (hit_drop != 8'hFF))
            hit_drop <= hit_drop + 8'd1;
    end
`endif
endmodule

// File: tb/tb_tdc_coarse_cnt.sv
// Randomized and directed bench for tdc_coarse_cnt against a queue-based window model.
module tb_tdc_coarse_cnt;
    localparam int CNT_W = 8;
    localparam int MAXC  = 200;
    localparam int DEPTH = 4;
    localparam int HC_W  = 3;

    logic             clk5 = 1'b0;
    logic             rst = 1'b1;
    logic             cnt_en = 1'b0;
    logic             coarse_tri = 1'b0;
    logic             hit_ready = 1'b1;
    logic             overflow;
    logic             hit_valid;
    logic             frame_done;
    logic [CNT_W-1:0] coarse_cnt;
    logic [CNT_W-1:0] hit_data;
    logic [HC_W-1:0]  hit_cnt;
`ifdef COARSE_DROP_CNT_EN
    logic [7:0]       hit_drop;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk5 = ~clk5;

    tdc_coarse_cnt #(
        .CNT_W     (CNT_W),
        .MAX_CNT   (MAXC),
        .HIT_DEPTH (DEPTH)
    ) dut (
        .clk5       (clk5),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .coarse_tri (coarse_tri),
        .overflow   (overflow),
        .coarse_cnt (coarse_cnt),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_data   (hit_data),
        .hit_cnt    (hit_cnt),
        .frame_done (frame_done)
`ifdef COARSE_DROP_CNT_EN
        ,
        .hit_drop   (hit_drop)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window model: phase of the measurement window plus elapsed run cycles and a hit queue.
    localparam int P_IDLE = 0, P_RUN = 1, P_OVF = 2, P_DONE = 3;
    int m_phase;
    int m_run;
    int m_q[$];
    int m_hits;
    int m_drops;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_run   = 0;
        m_q.delete();
        m_hits  = 0;
        m_drops = 0;
    endfunction

    function automatic void model_step(input logic en, input logic stop, input logic rdy);
        if (rdy && m_q.size() > 0)
            m_q.delete(0);
        case (m_phase)
            P_IDLE: if (en) begin
                m_phase = P_RUN;
                m_run   = 0;
                m_hits  = 0;
                m_drops = 0;
            end
            P_RUN: begin
                if (stop) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(m_run);
                        if (m_hits < DEPTH) m_hits++;
                    end else if (m_drops < 255) begin
                        m_drops++;
                    end
                end
                if (m_run == MAXC) m_phase = P_OVF;
                else if (!en) m_phase = P_DONE;
                else m_run++;
            end
            P_OVF:  if (!en) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
    endfunction

    function automatic int exp_cnt();
        if (m_phase == P_RUN) return m_run;
        if (m_phase == P_OVF) return MAXC;
        return 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk5);
            if (rst) begin
                model_reset();
            end else begin
                model_step(cnt_en, coarse_tri, hit_ready);
                #1;
                check("coarse_cnt", 32'(coarse_cnt), 32'(exp_cnt()));
                check("overflow", 32'(overflow), 32'(m_phase == P_OVF));
                check("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
                check("hit_valid", 32'(hit_valid), 32'(m_q.size() > 0));
                if (m_q.size() > 0) check("hit_data", 32'(hit_data), 32'(m_q[0]));
                check("hit_cnt", 32'(hit_cnt), 32'(m_hits));
`ifdef COARSE_DROP_CNT_EN
                check("hit_drop", 32'(hit_drop), 32'(m_drops));
`endif
            end
        end
    end

    // Observed pops, frame_done pulses and overflow cycles, sampled mid-cycle.
    int pops[$];
    int fd_cnt;
    int ovf_seen;
    always @(negedge clk5) begin
        if (!rst) begin
            if (hit_valid && hit_ready) pops.push_back(int'(hit_data));
            if (frame_done) fd_cnt++;
            if (overflow) ovf_seen++;
        end
    end

    task automatic cyc();
        @(posedge clk5);
        #2;
    endtask

    task automatic clear_obs();
        pops.delete();
        fd_cnt   = 0;
        ovf_seen = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_coarse_cnt"}, 32'(coarse_cnt), 0);
        check({tag, "_hit_valid"}, 32'(hit_valid), 0);
        check({tag, "_hit_data"}, 32'(hit_data), 0);
        check({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
`ifdef COARSE_DROP_CNT_EN
        check({tag, "_hit_drop"}, 32'(hit_drop), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    int exp_pops[5];
    int len;
    int gap;

    initial begin
        fd_cnt = 0;
        ovf_seen = 0;
        #8;
        check_reset_vals("reset");
        @(posedge clk5); #2;
        rst = 1'b0;
        cyc(); cyc();

        // Single hit at run cycle 17, 50-cycle window.
        clear_obs();
        cnt_en = 1'b1; cyc();
        check("single_first_cnt", 32'(coarse_cnt), 0);
        repeat (17) cyc();
        coarse_tri = 1'b1; cyc(); coarse_tri = 1'b0;
        repeat (31) cyc();
        cnt_en = 1'b0; cyc(); cyc();
        repeat (3) cyc();
        check("single_pop_count", 32'(pops.size()), 1);
        check("single_pop_val", (pops.size() > 0) ? 32'(pops[0]) : 32'hFFFF_FFFF, 17);
        check("single_hit_cnt", 32'(hit_cnt), 1);
        check("single_frame_done", 32'(fd_cnt), 1);
        check("single_no_ovf", 32'(ovf_seen), 0);

        // Overflow: hold window open until one cycle after overflow rises.
        clear_obs();
        cnt_en = 1'b1; cyc();
        for (int i = 0; i < 300 && overflow !== 1'b1; i++) cyc();
        check("ovf_rise", 32'(overflow), 1);
        check("ovf_cnt_at_rise", 32'(coarse_cnt), MAXC);
        cyc();
        check("ovf_cnt_hold", 32'(coarse_cnt), MAXC);
        cnt_en = 1'b0; cyc();
        check("ovf_done_pulse", 32'(frame_done), 1);
        check("ovf_fall", 32'(overflow), 0);
        cyc();
        check("ovf_frame_done_once", 32'(fd_cnt), 1);
        check("ovf_idle_cnt", 32'(coarse_cnt), 0);

        // Hit exactly at the range edge, second pulse inside OVF ignored.
        clear_obs();
        cnt_en = 1'b1; cyc();
        repeat (MAXC) cyc();
        check("edge_cnt", 32'(coarse_cnt), MAXC);
        coarse_tri = 1'b1; cyc();
        check("edge_ovf", 32'(overflow), 1);
        cyc();
        coarse_tri = 1'b0; cnt_en = 1'b0; cyc(); cyc();
        repeat (3) cyc();
        check("edge_pop_count", 32'(pops.size()), 1);
        check("edge_pop_val", (pops.size() > 0) ? 32'(pops[0]) : 32'hFFFF_FFFF, MAXC);

        // FIFO full with hit_ready low, then simultaneous push/pop at full.
        clear_obs();
        hit_ready = 1'b0;
        cnt_en = 1'b1; cyc();
        for (int c = 0; c < 15; c++) begin
            coarse_tri = (c >= 3) && (c % 2 == 1);
            cyc();
        end
        coarse_tri = 1'b0;
        check("full_hit_cnt", 32'(hit_cnt), 4);
        check("full_head", 32'(hit_data), 3);
        check("full_valid", 32'(hit_valid), 1);
`ifdef COARSE_DROP_CNT_EN
        check("full_drop", 32'(hit_drop), 2);
`endif
        repeat (5) cyc();
        check("full_cnt20", 32'(coarse_cnt), 20);
        coarse_tri = 1'b1; hit_ready = 1'b1; cyc();
        coarse_tri = 1'b0; hit_ready = 1'b0;
        check("simul_head", 32'(hit_data), 5);
`ifdef COARSE_DROP_CNT_EN
        check("simul_no_drop", 32'(hit_drop), 2);
`endif
        cnt_en = 1'b0; cyc(); cyc();
        hit_ready = 1'b1;
        repeat (6) cyc();
        exp_pops = '{3, 5, 7, 9, 20};
        check("full_pop_count", 32'(pops.size()), 5);
        for (int k = 0; k < 5; k++)
            check("full_pop_order", (pops.size() > k) ? 32'(pops[k]) : 32'hFFFF_FFFF, 32'(exp_pops[k]));

        // Reset mid-frame with two hits queued.
        clear_obs();
        hit_ready = 1'b0;
        cnt_en = 1'b1; cyc();
        for (int c = 0; c < 90; c++) begin
            coarse_tri = (c == 10) || (c == 30);
            cyc();
        end
        coarse_tri = 1'b0;
        check("rstmid_cnt", 32'(coarse_cnt), 90);
        check("rstmid_valid", 32'(hit_valid), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("rstmid");
        cnt_en = 1'b0; cyc();
        rst = 1'b0; hit_ready = 1'b1; cyc();
        cnt_en = 1'b1; cyc();
        check("rstmid_restart_cnt", 32'(coarse_cnt), 0);
        check("rstmid_restart_valid", 32'(hit_valid), 0);
        repeat (10) cyc();
        cnt_en = 1'b0; cyc(); cyc();

        // Randomized windows, stop pulses and consumer backpressure.
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 3) == 0) len = $urandom_range(205, 240);
            else len = $urandom_range(1, 120);
            cnt_en = 1'b1;
            for (int i = 0; i < len; i++) begin
                coarse_tri = ($urandom_range(0, 4) == 0);
                hit_ready  = $urandom_range(0, 1) == 1;
                cyc();
            end
            cnt_en = 1'b0;
            coarse_tri = 1'b0;
            gap = $urandom_range(0, 4);
            for (int i = 0; i < gap; i++) begin
                hit_ready = $urandom_range(0, 1) == 1;
                cyc();
            end
        end
        cnt_en = 1'b0;
        hit_ready = 1'b1;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
